// File: rtl/wb_gpio_v2_pkg.sv
// Register map, control-bit positions and byte-lane helper shared by the
// Wishbone GPIO block and its bench.
package wb_gpio_v2_pkg;

    localparam int REG_OFF_BITS = 6;
    localparam int WINDOW_BYTES = 64;

    typedef logic [REG_OFF_BITS-1:0] reg_off_t;

    localparam reg_off_t OFF_VERSION    = 6'h00;
    localparam reg_off_t OFF_DEVICE_ID  = 6'h04;
    localparam reg_off_t OFF_DIR        = 6'h08;
    localparam reg_off_t OFF_OUT        = 6'h0C;
    localparam reg_off_t OFF_IN         = 6'h10;
    localparam reg_off_t OFF_OUT_SET    = 6'h14;
    localparam reg_off_t OFF_OUT_CLR    = 6'h18;
    localparam reg_off_t OFF_IRQ_EN     = 6'h1C;
    localparam reg_off_t OFF_IRQ_RISE   = 6'h20;
    localparam reg_off_t OFF_IRQ_FALL   = 6'h24;
    localparam reg_off_t OFF_IRQ_STATUS = 6'h28;
    localparam reg_off_t OFF_DEBOUNCE   = 6'h2C;
    localparam reg_off_t OFF_CTRL       = 6'h30;

    localparam int CTRL_GIE_BIT = 31;

    // Spread one select bit per lane of 'gran' bits into a per-bit mask.
    function automatic logic [31:0] lane_mask(input logic [31:0] sel, input int gran);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 32; b++) begin
            m[b] = sel[b / gran];
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin two-flop synchroniser, counter debouncer and edge detector on the
// debounced level.
module gpio_debounce #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     pads,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic [WIDTH-1:0]     stable,
    output logic [WIDTH-1:0]     rise,
    output logic [WIDTH-1:0]     fall
);

    logic [WIDTH-1:0]     sync1;
    logic [WIDTH-1:0]     sync2;
    logic [WIDTH-1:0]     stable_d;
    logic [CNT_WIDTH-1:0] cnt [WIDTH];

    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // which is what makes sync1 -> sync2 -> stable a real pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            // NOTE: the counter array is per-pin control state, not storage,
            // so unlike a RAM every entry is cleared in reset.
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= pads;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == limit) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

endmodule

// File: rtl/wb_gpio_v2.sv
// Wishbone-pipelined GPIO block: direction/output registers, debounced inputs
// and per-pin edge interrupts behind a 64-byte register window.
module wb_gpio_v2
    import wb_gpio_v2_pkg::*;
#(
    parameter int                   WB_ADDRESS_WIDTH    = 32,
    parameter logic [63:0]          WB_BASE_ADDRESS     = 64'h0000_0000_4001_0000,
    parameter int                   WB_DATA_WIDTH       = 32,
    parameter int                   WB_DATA_GRANULARITY = 8,
    localparam int                  WB_SEL_WIDTH        = WB_DATA_WIDTH / WB_DATA_GRANULARITY,
    parameter int                   GPIO_WIDTH          = 32,
    parameter int                   DEBOUNCE_WIDTH      = 16,
    parameter logic [31:0]          IP_VERSION          = 32'h0002_0000,
    parameter logic [31:0]          IP_DEVICE_ID        = 32'h0001_0002,
    parameter logic [GPIO_WIDTH-1:0] DEFAULT_DIR        = '1,
    parameter logic [GPIO_WIDTH-1:0] DEFAULT_OUT        = '0
) (
    input  logic                        i_wb_clk,
    input  logic                        i_wb_rst_n,
    input  logic                        i_wb_cyc,
    input  logic                        i_wb_stb,
    input  logic                        i_wb_we,
    input  logic [WB_ADDRESS_WIDTH-1:0] i_wb_addr,
    input  logic [WB_DATA_WIDTH-1:0]    i_wb_dat,
    input  logic [WB_SEL_WIDTH-1:0]     i_wb_sel,
    output logic [WB_DATA_WIDTH-1:0]    o_wb_dat,
    output logic                        o_wb_stall,
    output logic                        o_wb_ack,
    input  logic [GPIO_WIDTH-1:0]       i_gpio,
    output logic [GPIO_WIDTH-1:0]       o_gpio,
    output logic [GPIO_WIDTH-1:0]       o_gpio_oe,
    output logic                        o_interrupt
);

    logic [63:0]               addr_ext;
    logic [63:0]               addr_rel;
    logic                      hit;
    reg_off_t                  reg_off;
    logic                      access;
    logic                      wr_en;
    logic                      rd_en;
    logic [31:0]               wmask;
    logic [31:0]               wbits;
    logic [GPIO_WIDTH-1:0]     wmask_g;
    logic [GPIO_WIDTH-1:0]     wbits_g;

    logic [GPIO_WIDTH-1:0]     dir;
    logic [GPIO_WIDTH-1:0]     out;
    logic [GPIO_WIDTH-1:0]     irq_en;
    logic [GPIO_WIDTH-1:0]     irq_rise;
    logic [GPIO_WIDTH-1:0]     irq_fall;
    logic [GPIO_WIDTH-1:0]     irq_status;
    logic [DEBOUNCE_WIDTH-1:0] debounce;
    logic                      gie;

    logic [GPIO_WIDTH-1:0]     in_stable;
    logic [GPIO_WIDTH-1:0]     rise;
    logic [GPIO_WIDTH-1:0]     fall;
    logic [GPIO_WIDTH-1:0]     status_set;
    logic [GPIO_WIDTH-1:0]     status_clr;

    logic [31:0]               rdata;
    logic [31:0]               dat_r;
    logic                      ack_r;
    logic                      irq_r;

    // Address decode: only the 64-byte window starting at the base is claimed.
    assign addr_ext = 64'(i_wb_addr);
    assign addr_rel = addr_ext - WB_BASE_ADDRESS;
    assign hit      = (addr_ext >= WB_BASE_ADDRESS) && (addr_rel < 64'(WINDOW_BYTES));
    assign reg_off  = addr_rel[REG_OFF_BITS-1:0];

    assign access = i_wb_cyc && i_wb_stb;
    assign wr_en  = access && i_wb_we && hit;
    assign rd_en  = access && !i_wb_we && hit;

    assign wmask   = lane_mask(32'(i_wb_sel), WB_DATA_GRANULARITY);
    assign wbits   = i_wb_dat & wmask;
    assign wmask_g = wmask[GPIO_WIDTH-1:0];
    assign wbits_g = wbits[GPIO_WIDTH-1:0];

    gpio_debounce #(
        .WIDTH     (GPIO_WIDTH),
        .CNT_WIDTH (DEBOUNCE_WIDTH)
    ) u_debounce (
        .clk    (i_wb_clk),
        .rst_n  (i_wb_rst_n),
        .pads   (i_gpio),
        .limit  (debounce),
        .stable (in_stable),
        .rise   (rise),
        .fall   (fall)
    );

    assign status_set = (rise & irq_rise) | (fall & irq_fall);
    assign status_clr = (wr_en && reg_off == OFF_IRQ_STATUS) ? wbits_g : '0;

    always_comb begin
        // NOTE: rdata gets a default before the case so no path leaves it
        // unassigned; a missing default here would infer a latch.
        rdata = '0;
        case (reg_off)
            OFF_VERSION:    rdata = IP_VERSION;
            OFF_DEVICE_ID:  rdata = IP_DEVICE_ID;
            OFF_DIR:        rdata = 32'(dir);
            OFF_OUT:        rdata = 32'(out);
            OFF_IN:         rdata = 32'(in_stable);
            OFF_IRQ_EN:     rdata = 32'(irq_en);
            OFF_IRQ_RISE:   rdata = 32'(irq_rise);
            OFF_IRQ_FALL:   rdata = 32'(irq_fall);
            OFF_IRQ_STATUS: rdata = 32'(irq_status);
            OFF_DEBOUNCE:   rdata = 32'(debounce);
            OFF_CTRL:       rdata[CTRL_GIE_BIT] = gie;
            default:        rdata = '0;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            dir        <= DEFAULT_DIR;
            out        <= DEFAULT_OUT;
            irq_en     <= '0;
            irq_rise   <= '0;
            irq_fall   <= '0;
            irq_status <= '0;
            debounce   <= '0;
            gie        <= 1'b0;
            ack_r      <= 1'b0;
            dat_r      <= '0;
            irq_r      <= 1'b0;
        end else begin
            ack_r <= access;
            dat_r <= rd_en ? rdata : '0;
            irq_r <= gie && |(irq_status & irq_en);

            // A new edge in the same cycle as a W1C keeps the bit set.
            irq_status <= (irq_status & ~status_clr) | status_set;

            if (wr_en) begin
                case (reg_off)
                    OFF_DIR:      dir      <= (dir & ~wmask_g) | wbits_g;
                    OFF_OUT:      out      <= (out & ~wmask_g) | wbits_g;
                    OFF_OUT_SET:  out      <= out | wbits_g;
                    OFF_OUT_CLR:  out      <= out & ~wbits_g;
                    OFF_IRQ_EN:   irq_en   <= (irq_en & ~wmask_g) | wbits_g;
                    OFF_IRQ_RISE: irq_rise <= (irq_rise & ~wmask_g) | wbits_g;
                    OFF_IRQ_FALL: irq_fall <= (irq_fall & ~wmask_g) | wbits_g;
                    OFF_DEBOUNCE: debounce <= (debounce & ~wmask[DEBOUNCE_WIDTH-1:0])
                                              | wbits[DEBOUNCE_WIDTH-1:0];
                    OFF_CTRL: begin
                        if (wmask[CTRL_GIE_BIT]) begin
                            gie <= i_wb_dat[CTRL_GIE_BIT];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Ack is withdrawn immediately if the master abandons the cycle.
    assign o_wb_ack    = ack_r && i_wb_cyc;
    assign o_wb_dat    = dat_r;
    assign o_wb_stall  = 1'b0;
    assign o_gpio      = out;
    assign o_gpio_oe   = dir;
    assign o_interrupt = irq_r;

endmodule

// File: tb/tb_wb_gpio_v2.sv
// Directed bench for wb_gpio_v2: expected read data is queued at issue time
// and compared when the ack arrives one cycle later.
module tb_wb_gpio_v2;
    import wb_gpio_v2_pkg::*;

    localparam logic [31:0] BASE = 32'h4001_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic [31:0] rdat;
    logic        stall;
    logic        ack;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;

    typedef struct {
        string       tag;
        logic        is_read;
        logic [31:0] exp;
    } txn_t;

    txn_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    wb_gpio_v2 dut (
        .i_wb_clk    (clk),
        .i_wb_rst_n  (rst_n),
        .i_wb_cyc    (cyc),
        .i_wb_stb    (stb),
        .i_wb_we     (we),
        .i_wb_addr   (addr),
        .i_wb_dat    (wdat),
        .i_wb_sel    (sel),
        .o_wb_dat    (rdat),
        .o_wb_stall  (stall),
        .o_wb_ack    (ack),
        .i_gpio      (gpio_in),
        .o_gpio      (gpio_out),
        .o_gpio_oe   (gpio_oe),
        .o_interrupt (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one access (caller is between clock edges) and queue its expectation.
    task automatic issue(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp);
        txn_t t;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        addr = a;
        wdat = d;
        sel  = s;
        t.tag     = tag;
        t.is_read = !w;
        t.exp     = exp;
        sb.push_back(t);
    endtask

    // Let the access be accepted, then check the ack and data one cycle later.
    task automatic complete();
        txn_t t;
        @(posedge clk);
        #1;
        stb = 1'b0;
        t = sb.pop_front();
        check({t.tag, "_ack"}, 32'(ack), 32'd1);
        if (t.is_read) check(t.tag, rdat, t.exp);
    endtask

    task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
        @(negedge clk);
        issue(tag, 1'b0, BASE + off, '0, 4'hF, exp);
        complete();
        cyc = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] d,
                      input logic [3:0] s);
        @(negedge clk);
        issue(tag, 1'b1, BASE + off, d, s, '0);
        complete();
        cyc = 1'b0;
    endtask

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_oe", gpio_oe, 32'hFFFF_FFFF);
        check("rst_out", gpio_out, 32'd0);
        check("stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        rd("version", 32'(OFF_VERSION), 32'h0002_0000);
        rd("device_id", 32'(OFF_DEVICE_ID), 32'h0001_0002);
        @(posedge clk);
        #1;
        check("ack_drop", 32'(ack), 32'd0);

        // Byte-selected DIR write.
        wr("dir_clr", 32'(OFF_DIR), 32'h0, 4'hF);
        wr("dir_b0", 32'(OFF_DIR), 32'h0000_00FF, 4'b0001);
        rd("dir_rd", 32'(OFF_DIR), 32'h0000_00FF);
        check("oe_pins", gpio_oe, 32'h0000_00FF);

        // OUT byte lanes, set and clear.
        wr("out_full", 32'(OFF_OUT), 32'hAABB_CCDD, 4'hF);
        wr("out_b2", 32'(OFF_OUT), 32'h1122_3344, 4'b0100);
        rd("out_lanes", 32'(OFF_OUT), 32'hAA22_CCDD);
        check("gpio_lanes", gpio_out, 32'hAA22_CCDD);
        wr("out_zero", 32'(OFF_OUT), 32'h0, 4'hF);
        wr("out_set", 32'(OFF_OUT_SET), 32'h0000_0005, 4'hF);
        wr("out_clr", 32'(OFF_OUT_CLR), 32'h0000_0001, 4'hF);
        rd("out_setclr", 32'(OFF_OUT), 32'h0000_0004);
        check("gpio_setclr", gpio_out, 32'h0000_0004);
        wr("out_set_b1", 32'(OFF_OUT_SET), 32'h0100_0100, 4'b0010);
        wr("out_clr_b0", 32'(OFF_OUT_CLR), 32'h0000_0104, 4'b0001);
        rd("out_sel_sc", 32'(OFF_OUT), 32'h0000_0100);

        // Back-to-back reads ack every cycle.
        @(negedge clk);
        issue("b2b_ver", 1'b0, BASE + 32'(OFF_VERSION), '0, 4'hF, 32'h0002_0000);
        complete();
        issue("b2b_dir", 1'b0, BASE + 32'(OFF_DIR), '0, 4'hF, 32'h0000_00FF);
        complete();
        issue("b2b_dev", 1'b0, BASE + 32'(OFF_DEVICE_ID), '0, 4'hF, 32'h0001_0002);
        complete();
        cyc = 1'b0;

        // Debounce of 3: a 2-cycle pulse is filtered out.
        wr("db3", 32'(OFF_DEBOUNCE), 32'd3, 4'hF);
        rd("db3_rd", 32'(OFF_DEBOUNCE), 32'd3);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (10) @(negedge clk);
        rd("in_pulse", 32'(OFF_IN), 32'd0);

        // Held level: stable flips on edge 6, so a read accepted on edge 7 sees it.
        @(negedge clk);
        gpio_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            issue($sformatf("in_db3_e%0d", k), 1'b0, BASE + 32'(OFF_IN), '0, 4'hF,
                  (k >= 7) ? 32'd1 : 32'd0);
            complete();
        end
        cyc = 1'b0;

        // Debounce of 0: pad-to-IN is 3 cycles, so a read on edge 4 sees it.
        wr("db0", 32'(OFF_DEBOUNCE), 32'd0, 4'hF);
        @(negedge clk);
        gpio_in[1] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            issue($sformatf("in_db0_e%0d", k), 1'b0, BASE + 32'(OFF_IN), '0, 4'hF,
                  (k >= 4) ? 32'd3 : 32'd1);
            complete();
        end
        cyc = 1'b0;
        @(negedge clk);
        gpio_in = '0;
        repeat (6) @(negedge clk);

        // Rise interrupt, then W1C.
        wr("irq_rise", 32'(OFF_IRQ_RISE), 32'd1, 4'hF);
        wr("irq_en", 32'(OFF_IRQ_EN), 32'd1, 4'hF);
        wr("ctrl", 32'(OFF_CTRL), 32'h8000_0000, 4'hF);
        wr("ctrl_lo", 32'(OFF_CTRL), 32'h0, 4'b0111);
        rd("ctrl_rd", 32'(OFF_CTRL), 32'h8000_0000);
        rd("status_idle", 32'(OFF_IRQ_STATUS), 32'd0);
        check("irq_idle", 32'(irq), 32'd0);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (6) @(negedge clk);
        rd("status_rise", 32'(OFF_IRQ_STATUS), 32'd1);
        check("irq_rise", 32'(irq), 32'd1);
        wr("status_w1c", 32'(OFF_IRQ_STATUS), 32'd1, 4'hF);
        check("irq_lag", 32'(irq), 32'd1);
        @(posedge clk);
        #1;
        check("irq_clear", 32'(irq), 32'd0);
        rd("status_clear", 32'(OFF_IRQ_STATUS), 32'd0);

        // W1C landing on the same edge as a new fall event: set wins.
        wr("irq_fall", 32'(OFF_IRQ_FALL), 32'd1, 4'hF);
        @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        issue("w1c_race", 1'b1, BASE + 32'(OFF_IRQ_STATUS), 32'd1, 4'hF, '0);
        complete();
        cyc = 1'b0;
        rd("status_set_wins", 32'(OFF_IRQ_STATUS), 32'd1);
        wr("status_w1c2", 32'(OFF_IRQ_STATUS), 32'd1, 4'hF);
        rd("status_clear2", 32'(OFF_IRQ_STATUS), 32'd0);

        // Unmapped and out-of-window accesses.
        rd("unmapped_3c", 32'h3C, 32'd0);
        rd("oow_40", 32'h40, 32'd0);
        @(negedge clk);
        issue("below_base", 1'b0, BASE - 32'd4, '0, 4'hF, 32'd0);
        complete();
        cyc = 1'b0;
        wr("ver_wr", 32'(OFF_VERSION), 32'h0, 4'hF);
        rd("ver_ro", 32'(OFF_VERSION), 32'h0002_0000);

        // Master drops cyc in the ack cycle.
        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b0;
        addr = BASE + 32'(OFF_DIR);
        @(posedge clk);
        #1;
        cyc = 1'b0;
        stb = 1'b0;
        #1;
        check("cyc_drop_ack", 32'(ack), 32'd0);
        @(posedge clk);
        #1;
        check("cyc_drop_next", 32'(ack), 32'd0);

        // Reset during an access.
        wr("db5", 32'(OFF_DEBOUNCE), 32'd5, 4'hF);
        @(negedge clk);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = 1'b0;
        addr  = BASE + 32'(OFF_DIR);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_dat", rdat, 32'd0);
        check("rst_mid_oe", gpio_oe, 32'hFFFF_FFFF);
        check("rst_mid_out", gpio_out, 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        @(negedge clk);
        cyc = 1'b0;
        stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd("post_dir", 32'(OFF_DIR), 32'hFFFF_FFFF);
        rd("post_out", 32'(OFF_OUT), 32'd0);
        rd("post_db", 32'(OFF_DEBOUNCE), 32'd0);
        rd("post_en", 32'(OFF_IRQ_EN), 32'd0);
        rd("post_rise", 32'(OFF_IRQ_RISE), 32'd0);
        rd("post_ctrl", 32'(OFF_CTRL), 32'd0);
        rd("post_status", 32'(OFF_IRQ_STATUS), 32'd0);

        // First edge of the debounced level after reset is a real rise.
        wr("post_irq_rise", 32'(OFF_IRQ_RISE), 32'd1, 4'hF);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (6) @(negedge clk);
        rd("post_rise_status", 32'(OFF_IRQ_STATUS), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
